// File: rtl/mux6_rr_scheduler.sv
// mux6_rr_scheduler: round-robin sharing of one 2**SEL_W:1 bit mux among N_REQ readers
module mux6_rr_scheduler #(
  parameter int N_REQ      = 4,
  parameter int SEL_W      = 6,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*SEL_W-1:0] req_sel_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [SEL_W-1:0]       mux_sel_o,
  input  logic                   mux_out_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic                   rsp_data_o,
  output logic                   busy_o
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, gid;
  logic [3:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, gsel;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic rsp_data_q, rsp_data_d, hit;
  always_comb begin
    int j;
    j = 0;
    hit = 1'b0;
    gid = '0;
    gsel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!hit && req_valid_i[j]) begin
        hit = 1'b1;
        gid = IW'(j);
        gsel = req_sel_i[j*SEL_W +: SEL_W];
      end
    end
  end
  assign req_ready_o = (state_q == IDLE && hit && !rst) ? N_REQ'(1) << gid : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = SETTLE;
        sel_d = gsel;
        own_d = gid;
        cnt_d = 4'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        state_d = (cnt_q == 4'd0) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        rsp_data_d = mux_out_i;
        rsp_valid_d = N_REQ'(1) << own_q;
        ptr_d = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign mux_sel_o = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_mux6_rr_scheduler.sv
// tb_mux6_rr_scheduler: three scheduler instances (SETTLE_CYC 1/3/4) against a transaction-level model
module tb_mux6_rr_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [23:0] req_sel;
  logic [63:0] mux_data;
  logic glitch_en, glitch_val;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int S = (k == 0) ? 1 : (k == 1) ? 3 : 4;
    logic [3:0] ready, rsp_valid;
    logic [5:0] mux_sel;
    logic rsp_data, busy, mux_out;
    assign mux_out = glitch_en ? glitch_val : mux_data[mux_sel];
    mux6_rr_scheduler #(.N_REQ(4), .SEL_W(6), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_sel_i(req_sel),
      .req_ready_o(ready), .mux_sel_o(mux_sel), .mux_out_i(mux_out),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy));
    // left = cycles this transaction still occupies the mux after the grant cycle
    int left = 0, ptr = 0, owner = 0, gw;
    logic [3:0] rv = '0;
    logic rd = 1'b0;
    logic [5:0] msel = '0;
    always @(negedge clk) begin
      gw = pick(ptr, req_valid);
      chk($sformatf("S%0d ready", S), 32'(ready), (!rst && left == 0 && gw >= 0) ? (1 << gw) : 0);
      chk($sformatf("S%0d busy", S), 32'(busy), 32'(left > 0));
      chk($sformatf("S%0d rsp_valid", S), 32'(rsp_valid), 32'(rv));
      if (rv != 0) chk($sformatf("S%0d rsp_data", S), 32'(rsp_data), 32'(rd));
      chk($sformatf("S%0d mux_sel", S), 32'(mux_sel), 32'(msel));
      if (rst) begin
        left = 0; ptr = 0; rv = '0; msel = '0; rd = 1'b0;
      end else begin
        rv = '0;
        if (left == 1) begin
          rv = 4'(1 << owner);
          rd = glitch_en ? glitch_val : mux_data[msel];
          ptr = (owner + 1) % 4;
        end
        if (left > 0) left--;
        else if (gw >= 0) begin
          owner = gw;
          msel = req_sel[gw*6 +: 6];
          left = S + 1;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1);
  end
  initial begin
    int n;
    logic [5:0] sels [3] = '{6'd63, 6'd0, 6'd1};
    logic exps [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] wr [3] = '{4'b1000, 4'b0010, 4'b1000};
    rst = 1'b1; req_valid = 4'hF; req_sel = '0; mux_data = '0; glitch_en = 1'b0; glitch_val = 1'b0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t1 first grant S1", 32'(g[0].ready), 32'h1);
    chk("t1 first grant S4", 32'(g[2].ready), 32'h1);
    tick(1); req_valid = '0; tick(8);
    mux_data = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0100; req_sel[12 +: 6] = sels[i];
      @(negedge clk);
      chk("t2 grant", 32'(g[0].ready), 32'h4);
      tick(1); req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("t2 early rsp", 32'(g[0].rsp_valid), 32'h0);
      @(negedge clk);
      chk("t2 rsp_valid", 32'(g[0].rsp_valid), 32'h4);
      chk("t2 rsp_data", 32'(g[0].rsp_data), 32'(exps[i]));
      tick(6);
    end
    rst = 1'b1; tick(1); rst = 1'b0;
    mux_data = 64'hDEAD_BEEF_0123_4567;
    req_sel = {6'd40, 6'd30, 6'd21, 6'd10};
    req_valid = 4'hF;
    for (int t = 0; t < 12; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (g[0].ready == 0 && n < 10);
      chk("t3 rr grant", 32'(g[0].ready), 32'(1 << (t % 4)));
    end
    tick(1); req_valid = '0; tick(8);
    rst = 1'b1; tick(1); rst = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    tick(1); req_valid = '0; tick(8);
    req_valid = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (g[0].ready == 0 && n < 10);
      chk("t4 wrap grant", 32'(g[0].ready), 32'(wr[t]));
    end
    tick(1); req_valid = '0; tick(8);
    req_valid = 4'b0010;
    @(negedge clk);
    tick(1); req_valid = '0; tick(8);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5 grant", 32'(g[2].ready), 32'h4);
    tick(1); req_valid = '0;
    tick(1); rst = 1'b1;
    @(negedge clk);
    chk("t5 busy in settle", 32'(g[2].busy), 32'h1);
    tick(1); rst = 1'b0; req_valid = 4'b1010;
    @(negedge clk);
    chk("t5 idle after rst", 32'(g[2].busy), 32'h0);
    chk("t5 no rsp", 32'(g[2].rsp_valid), 32'h0);
    chk("t5 lowest grant", 32'(g[2].ready), 32'h2);
    tick(1); req_valid = '0; tick(8);
    mux_data = 64'h0000_0000_0000_0020;
    req_sel[0 +: 6] = 6'd5; req_valid = 4'b0001;
    @(negedge clk);
    chk("t6 grant", 32'(g[1].ready), 32'h1);
    tick(1); req_valid = '0; req_sel[0 +: 6] = 6'd9; glitch_en = 1'b1; glitch_val = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6 sel hold", 32'(g[1].mux_sel), 32'd5);
      tick(1); glitch_val = ~glitch_val;
      if (c == 3) glitch_en = 1'b0;
    end
    @(negedge clk);
    chk("t6 rsp_valid", 32'(g[1].rsp_valid), 32'h1);
    chk("t6 rsp_data", 32'(g[1].rsp_data), 32'h0);
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
